// File: rtl/prio_enc_stream.sv
// Handshaked priority encoder: reports the top-priority set bit, or every set bit in multi mode.
// Latency: result beat valid the cycle after accept; backpressure holds the beat, no input buffering.
module prio_enc_stream #(
    parameter int                WIDTH      = 16,
    parameter int                OUT_W      = 8,
    parameter logic [OUT_W-1:0]  EMPTY_CODE = OUT_W'(8'hF0),
    localparam int               CNT_W      = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_lsb_first,
    input  logic             in_multi,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_idx,
    output logic             out_empty,
    output logic             out_last,
    output logic [CNT_W-1:0] out_cnt
);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sh_q, sh_d;
    logic               lsb_q, lsb_d;
    logic               multi_q, multi_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [WIDTH-1:0]   sel;
    logic [OUT_W-1:0]   idx;
    logic               sh_empty;
    logic               beat_last;

    // Later iterations overwrite earlier ones, so the scan order picks the winner.
    always_comb begin
        sel = '0;
        idx = '0;
        if (lsb_q) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (sh_q[i]) begin
                    sel    = '0;
                    sel[i] = 1'b1;
                    idx    = OUT_W'(i);
                end
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sh_q[i]) begin
                    sel    = '0;
                    sel[i] = 1'b1;
                    idx    = OUT_W'(i);
                end
            end
        end
        sh_empty  = (sh_q == '0);
        beat_last = !multi_q || ((sh_q & (sh_q - WIDTH'(1))) == '0);
    end

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        lsb_d   = lsb_q;
        multi_d = multi_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = SCAN;
                    sh_d    = in_data;
                    lsb_d   = in_lsb_first;
                    multi_d = in_multi;
                    cnt_d   = '0;
                end
            end
            SCAN: begin
                if (out_ready) begin
                    if (beat_last) begin
                        state_d = IDLE;
                    end else begin
                        sh_d  = sh_q & ~sel;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sh_q    <= '0;
            lsb_q   <= 1'b0;
            multi_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            lsb_q   <= lsb_d;
            multi_q <= multi_d;
            cnt_q   <= cnt_d;
        end
    end

    // Result fields read as zero whenever no beat is on offer.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == SCAN);
        out_idx   = '0;
        out_empty = 1'b0;
        out_last  = 1'b0;
        out_cnt   = '0;
        if (out_valid) begin
            out_idx   = sh_empty ? EMPTY_CODE : idx;
            out_empty = sh_empty;
            out_last  = beat_last;
            out_cnt   = cnt_q;
        end
    end

endmodule

// File: tb/tb_prio_enc_stream.sv
// Directed and random words checked beat-by-beat against a set-bit-list model of the encoder.
module tb_prio_enc_stream;

    localparam int WIDTH = 16;
    localparam int OUT_W = 8;
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_lsb_first;
    logic             in_multi;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_idx;
    logic             out_empty;
    logic             out_last;
    logic [CNT_W-1:0] out_cnt;

    int checks = 0;
    int errors = 0;

    prio_enc_stream #(.WIDTH(WIDTH), .OUT_W(OUT_W), .EMPTY_CODE(8'hF0)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_lsb_first (in_lsb_first),
        .in_multi     (in_multi),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_idx      (out_idx),
        .out_empty    (out_empty),
        .out_last     (out_last),
        .out_cnt      (out_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_in_ready"},  32'(in_ready), 32'd1);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_zero_outs"}, {out_idx, out_empty, out_last, 32'(out_cnt)}, 32'd0);
    endtask

    // Expected beat list: indices of set bits in priority order; a zero word gives one EMPTY beat.
    task automatic run_word(input logic [WIDTH-1:0] w, input logic lsb, input logic multi,
                            input int max_stall, input logic offer_during_scan);
        int bits[$];
        int n;
        int st;
        int waited;
        bits = {};
        for (int k = 0; k < WIDTH; k++) begin
            int pos = lsb ? k : WIDTH - 1 - k;
            if (w[pos]) bits.push_back(pos);
        end
        if (!multi && bits.size() > 1) bits = bits[0:0];
        n = (bits.size() == 0) ? 1 : bits.size();

        waited = 0;
        while (!in_ready && waited < 20) begin
            step();
            waited++;
        end
        if (!in_ready) begin
            chk("wait_in_ready", 32'(in_ready), 32'd1);
            return;
        end

        in_valid     = 1'b1;
        in_data      = w;
        in_lsb_first = lsb;
        in_multi     = multi;
        out_ready    = 1'b0;
        step();
        if (offer_during_scan) begin
            in_data  = '1;
            in_multi = 1'b1;
        end else begin
            in_valid = 1'b0;
        end
        chk("latency_out_valid", 32'(out_valid), 32'd1);
        chk("scan_in_ready", 32'(in_ready), 32'd0);

        for (int b = 0; b < n; b++) begin
            st = (max_stall > 0) ? int'($urandom_range(0, max_stall)) : 0;
            for (int s = 0; s <= st; s++) begin
                out_ready = (s == st);
                chk("beat_valid", 32'(out_valid), 32'd1);
                chk("beat_idx",   32'(out_idx), (bits.size() == 0) ? 32'hF0 : 32'(bits[b]));
                chk("beat_empty", 32'(out_empty), 32'(bits.size() == 0));
                chk("beat_last",  32'(out_last), 32'(b == n - 1));
                chk("beat_cnt",   32'(out_cnt), 32'(b));
                step();
            end
        end
        out_ready = 1'b0;
        chk_idle_outputs("after_word");
        in_valid = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        in_valid     = 1'b0;
        in_data      = '0;
        in_lsb_first = 1'b0;
        in_multi     = 1'b0;
        out_ready    = 1'b0;
        step();
        step();
        chk_idle_outputs("reset");
        rst = 1'b0;
        step();
        chk_idle_outputs("post_reset");

        run_word(16'h0A00, 1'b0, 1'b0, 0, 1'b0);
        run_word(16'h0A00, 1'b1, 1'b0, 0, 1'b0);
        run_word(16'h8421, 1'b0, 1'b1, 0, 1'b0);
        run_word(16'h0000, 1'b0, 1'b1, 0, 1'b1);
        step();
        chk_idle_outputs("ignored_offer");

        // Backpressure: first beat held for three stalled cycles.
        in_valid = 1'b1; in_data = 16'h0003; in_lsb_first = 1'b1; in_multi = 1'b1;
        step();
        in_valid = 1'b0;
        for (int s = 0; s < 3; s++) begin
            chk("bp_held_idx", 32'(out_idx), 32'd0);
            chk("bp_held_cnt", 32'(out_cnt), 32'd0);
            chk("bp_held_last", 32'(out_last), 32'd0);
            step();
        end
        out_ready = 1'b1;
        chk("bp_beat0_idx", 32'(out_idx), 32'd0);
        step();
        chk("bp_beat1_idx", 32'(out_idx), 32'd1);
        chk("bp_beat1_last", 32'(out_last), 32'd1);
        chk("bp_beat1_cnt", 32'(out_cnt), 32'd1);
        step();
        out_ready = 1'b0;
        chk_idle_outputs("bp_done");

        // Reset mid-scan wins over a simultaneous output handshake.
        in_valid = 1'b1; in_data = 16'hFFFF; in_lsb_first = 1'b0; in_multi = 1'b1;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("rst_beat0_idx", 32'(out_idx), 32'd15);
        step();
        chk("rst_beat1_idx", 32'(out_idx), 32'd14);
        rst = 1'b1;
        step();
        rst = 1'b0;
        out_ready = 1'b0;
        chk_idle_outputs("mid_scan_reset");
        run_word(16'h0001, 1'b0, 1'b0, 0, 1'b0);

        for (int t = 0; t < 60; t++) begin
            logic [WIDTH-1:0] w;
            w = WIDTH'($urandom);
            if (t % 7 == 0) w = '0;
            else if (t % 5 == 0) w = WIDTH'(1) << $urandom_range(0, WIDTH - 1);
            run_word(w, 1'($urandom), 1'($urandom), 2, 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
